// File: rtl/mem_wb_stage_if.sv
// MEM -> WB request bus: instruction fields presented by the MEM stage
// and the ready signal returned by the write-back stage.
interface mem_wb_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic              in_reg_write;
  logic [ADDR_W-1:0] in_rd;
  logic              in_mem_to_reg;
  logic [2:0]        in_load_type;
  logic [1:0]        in_addr_lo;
  logic [DATA_W-1:0] in_alu_result;
  logic [DATA_W-1:0] in_load_data;

  modport master (
    output in_valid, in_reg_write, in_rd, in_mem_to_reg, in_load_type,
           in_addr_lo, in_alu_result, in_load_data,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_reg_write, in_rd, in_mem_to_reg, in_load_type,
           in_addr_lo, in_alu_result, in_load_data,
    output in_ready
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and write-back: load alignment/extension, result
// select, register-file write port, two forwarding sources and a retire counter.
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  mem_wb_stage_if.slave     mem,
  input  logic              stall,
  input  logic              flush,
  output logic              reg_write,
  output logic [ADDR_W-1:0] rd,
  output logic [DATA_W-1:0] write_data,
  output logic              fwd0_valid,
  output logic [ADDR_W-1:0] fwd0_rd,
  output logic [DATA_W-1:0] fwd0_data,
  output logic              fwd1_valid,
  output logic [ADDR_W-1:0] fwd1_rd,
  output logic [DATA_W-1:0] fwd1_data,
  output logic              load_fault,
  output logic [31:0]       retired_count
);

  localparam logic [2:0] LT_LW  = 3'b000;
  localparam logic [2:0] LT_LB  = 3'b001;
  localparam logic [2:0] LT_LBU = 3'b010;
  localparam logic [2:0] LT_LH  = 3'b011;
  localparam logic [2:0] LT_LHU = 3'b100;

  // Picks the addressed byte/half of the little-endian word and extends it.
  function automatic logic [DATA_W-1:0] load_extend(input logic [2:0] lt,
                                                    input logic [1:0] alo,
                                                    input logic [DATA_W-1:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    case (alo)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      2'd3:    b = d[31:24];
      default: b = d[7:0];
    endcase
    h = alo[1] ? d[31:16] : d[15:0];
    case (lt)
      LT_LW:   load_extend = d;
      LT_LB:   load_extend = {{(DATA_W-8){b[7]}}, b};
      LT_LBU:  load_extend = {{(DATA_W-8){1'b0}}, b};
      LT_LH:   load_extend = {{(DATA_W-16){h[15]}}, h};
      LT_LHU:  load_extend = {{(DATA_W-16){1'b0}}, h};
      default: load_extend = d;
    endcase
  endfunction

  function automatic logic load_bad(input logic [2:0] lt, input logic [1:0] alo);
    case (lt)
      LT_LW:         load_bad = (alo != 2'b00);
      LT_LB, LT_LBU: load_bad = 1'b0;
      LT_LH, LT_LHU: load_bad = alo[0];
      default:       load_bad = 1'b1;
    endcase
  endfunction

  logic              wb_valid_r;
  logic              wb_reg_write_r;
  logic [ADDR_W-1:0] wb_rd_r;
  logic              wb_mem_to_reg_r;
  logic [2:0]        wb_load_type_r;
  logic [1:0]        wb_addr_lo_r;
  logic [DATA_W-1:0] wb_alu_result_r;
  logic [DATA_W-1:0] wb_load_data_r;
  logic              fwd1_valid_r;
  logic [ADDR_W-1:0] fwd1_rd_r;
  logic [DATA_W-1:0] fwd1_data_r;
  logic [31:0]       retired_count_r;
  logic              fault_s;
  logic              write_s;
  logic [DATA_W-1:0] result_s;

  assign mem.in_ready = ~stall;

  // Stage register: flush kills, stall holds, otherwise capture from MEM.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_r      <= 1'b0;
      wb_reg_write_r  <= 1'b0;
      wb_rd_r         <= '0;
      wb_mem_to_reg_r <= 1'b0;
      wb_load_type_r  <= 3'b000;
      wb_addr_lo_r    <= 2'b00;
      wb_alu_result_r <= '0;
      wb_load_data_r  <= '0;
    end else if (flush) begin
      wb_valid_r <= 1'b0;
    end else if (!stall) begin
      wb_valid_r      <= mem.in_valid;
      wb_reg_write_r  <= mem.in_reg_write;
      wb_rd_r         <= mem.in_rd;
      wb_mem_to_reg_r <= mem.in_mem_to_reg;
      wb_load_type_r  <= mem.in_load_type;
      wb_addr_lo_r    <= mem.in_addr_lo;
      wb_alu_result_r <= mem.in_alu_result;
      wb_load_data_r  <= mem.in_load_data;
    end
  end

  // Write-back result, fault detection and write enable.
  always_comb begin
    fault_s  = 1'b0;
    result_s = wb_alu_result_r;
    if (wb_mem_to_reg_r) begin
      result_s = load_extend(wb_load_type_r, wb_addr_lo_r, wb_load_data_r);
      fault_s  = wb_valid_r & load_bad(wb_load_type_r, wb_addr_lo_r);
    end else begin
      result_s = wb_alu_result_r;
      fault_s  = 1'b0;
    end
    write_s = wb_valid_r & wb_reg_write_r & (wb_rd_r != '0) & ~fault_s;
  end

  // Write history runs every cycle, so a stalled repeat write stays visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd1_valid_r <= 1'b0;
      fwd1_rd_r    <= '0;
      fwd1_data_r  <= '0;
    end else begin
      fwd1_valid_r <= write_s;
      fwd1_rd_r    <= wb_rd_r;
      fwd1_data_r  <= result_s;
    end
  end

  // Retire counter: an entry retires when it leaves WB unkilled; wraps freely.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_count_r <= 32'd0;
    end else if (wb_valid_r && !stall && !flush) begin
      retired_count_r <= retired_count_r + 32'd1;
    end
  end

  assign reg_write     = write_s;
  assign rd            = wb_rd_r;
  assign write_data    = result_s;
  assign fwd0_valid    = write_s;
  assign fwd0_rd       = wb_rd_r;
  assign fwd0_data     = result_s;
  assign fwd1_valid    = fwd1_valid_r;
  assign fwd1_rd       = fwd1_rd_r;
  assign fwd1_data     = fwd1_data_r;
  assign load_fault    = fault_s;
  assign retired_count = retired_count_r;

endmodule
